reg_file_ctrl: RTL and testbench
================================

# reg_file_ctrl

Port controller and arbiter for the 16-entry register file and its accumulator (entry 15). After reset it sequences a clear of all 16 entries. It then shares the single address/write port between the core datapath and a debug/loader requester. The core has priority, and a starvation limit guarantees debug access. It sits between the core's decode/writeback logic and the register file, and drives every register-file control input.

## Interface
- W, 8, data path width
- D, 4, register address width (2**D entries)
- ACC_ADDR, 15, accumulator entry index
- STARVE_LIM, 4, number of RUN cycles a debug request may wait before it is forced through
- CLK  input  1  clock
- Reset  input  1  asynchronous, active-high reset (one clock domain; polarity and asynchronous assertion are fixed)
- core_addr  input  D  core register address (read and write)
- core_reg_we  input  1  core general-register write request
- core_acc_we  input  1  core accumulator write request
- core_data  input  W  core write data
- core_hold  input  1  core does not need the port this cycle (bubble)
- core_stall  output  1  port not owned by core; core write dropped, core must hold state
- dbg_req  input  1  debug access request, held until dbg_ack
- dbg_we  input  1  debug access is a write (else read)
- dbg_addr  input  D  debug address
- dbg_wdata  input  W  debug write data
- dbg_ack  output  1  one-cycle completion pulse
- dbg_rdata  output  W  registered debug read data
- rf_addr  output  D  to register file raddr_reg
- rf_reg_write_en  output  1  to register file reg_write_en
- rf_acc_write_en  output  1  to register file acc_write_en
- rf_data_in  output  W  to register file data_in
- rf_data_out_reg  input  W  from register file data_out_reg
- init_done  output  1  clear sequence complete

## Operation
- States: INIT, RUN, DBG.
  - Reset forces INIT and init_cnt=0.
- INIT drives rf_reg_write_en=1, rf_addr=init_cnt, rf_data_in=0, rf_acc_write_en=0, and core_stall=1.
  - init_cnt increments on each edge.
  - The edge that writes entry 15 moves the state to RUN.
- RUN drives rf_addr=core_addr and rf_data_in=core_data.
  - rf_acc_write_en=core_acc_we.
  - rf_reg_write_en=core_reg_we & ~core_acc_we. The two enables are never both high; the accumulator write wins.
- Grant condition in RUN: dbg_req & ~dbg_ack & (core_hold | starve_cnt==STARVE_LIM). When true, next state is DBG.
- starve_cnt:
  - cleared on grant and whenever dbg_req=0;
  - otherwise increments each RUN cycle that dbg_req=1 and the grant condition is false;
  - saturates at STARVE_LIM.
- DBG lasts exactly one cycle, then returns to RUN.
  - Drives rf_addr=dbg_addr, rf_reg_write_en=dbg_we, rf_acc_write_en=0, rf_data_in=dbg_wdata.
  - dbg_addr=ACC_ADDR writes the accumulator through the register path.
- Debug read is read-before-write: dbg_rdata captures rf_data_out_reg at the end of the DBG cycle.
- core_stall = (state != RUN). Core write requests presented while stalled are dropped, not queued.
- dbg_req is ignored during the cycle dbg_ack is high. The requester drops dbg_req or issues a new request after that cycle.
- Reset asserted mid-INIT or mid-DBG aborts immediately. Any DBG access in flight is lost (no ack), and the clear restarts from entry 0.

## Timing
- Reset values:
  - core_stall=1, init_done=0, dbg_ack=0, dbg_rdata=0;
  - rf_reg_write_en=0, rf_acc_write_en=0, rf_addr=0, rf_data_in=0.
  - All rf_* outputs are forced to 0 while Reset is high.
- Clear: 16 edges after Reset deasserts, state=RUN. init_done is registered and rises in the first RUN cycle.
- Debug latency: DBG is entered on the edge after the grant condition; dbg_ack and dbg_rdata are valid on the following edge.
  - Minimum request-to-ack is 2 edges.
  - Worst case with core never holding is STARVE_LIM+2 edges.
- core_stall is a registered state decode: high for exactly one cycle per debug access, low otherwise in RUN.
- All rf_* outputs are combinational from state, counters and requester inputs. There is no added write latency; register-file writes land on the same edge.

## Structure
- Package reg_ctrl_pkg holds:
  - the state enum (INIT, RUN, DBG);
  - localparams ACC_ADDR=15 and NUM_REGS=2**D;
  - the debug request struct (we, addr, wdata).
- A single flat module holds the state register, init_cnt (D bits), starve_cnt ($clog2(STARVE_LIM+1) bits) and the dbg_rdata/dbg_ack registers.
- No sub-module. The register file is instantiated beside this block by the parent, not inside it.

## Test plan
- Reset release with no requests -> 16 consecutive zero writes to addresses 0..15, then init_done=1 on cycle 17; debug reads of r3 and r15 return 0.
- RUN, core_acc_we=1 and core_reg_we=1 with core_addr=5, data 8'hA7 -> only rf_acc_write_en high; r15=8'hA7, r5 unchanged.
- Debug write r9=8'h3C while core_hold=1 -> DBG next cycle, core_stall high for exactly that cycle, dbg_ack 2 edges after dbg_req; a subsequent debug read of r9 returns 8'h3C.
- dbg_req held, core_hold=0 continuously, STARVE_LIM=4 -> grant after 4 waiting cycles, ack at edge 6; a core write presented during the DBG cycle is dropped.
- Debug write r2=8'h11 after r2 was preset to 8'h55 -> dbg_rdata=8'h55 (read-before-write), r2=8'h11 afterward.
- Reset pulsed during init_cnt=7, and again during a DBG cycle -> no dbg_ack, init restarts at 0, and all 16 entries are zero after init_done.

Source files
------------

// File: rtl/reg_ctrl_pkg.sv
// Shared types and constants for the register-file port controller.
package reg_ctrl_pkg;

    localparam int REG_W    = 8;
    localparam int REG_D    = 4;
    localparam int NUM_REGS = 2 ** REG_D;
    localparam int ACC_ADDR = 15;

    // Port ownership: clearing after reset, core datapath, or one debug slot.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DBG  = 2'd2
    } ctrl_state_e;

    // One debug/loader access as presented by the requester.
    typedef struct packed {
        logic             we;
        logic [REG_D-1:0] addr;
        logic [REG_W-1:0] wdata;
    } dbg_req_t;

endpackage

// File: rtl/reg_file_ctrl.sv
// Port controller and arbiter for the 16-entry register file. Clears every
// entry after reset, then shares the single address/write port between the
// core datapath (priority) and a debug/loader requester that is guaranteed
// service after a bounded number of waiting cycles.
module reg_file_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int W          = REG_W,
    parameter int D          = REG_D,
    parameter int STARVE_LIM = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [D-1:0] core_addr,
    input  logic         core_reg_we,
    input  logic         core_acc_we,
    input  logic [W-1:0] core_data,
    input  logic         core_hold,
    output logic         core_stall,
    input  logic         dbg_req,
    input  logic         dbg_we,
    input  logic [D-1:0] dbg_addr,
    input  logic [W-1:0] dbg_wdata,
    output logic         dbg_ack,
    output logic [W-1:0] dbg_rdata,
    output logic [D-1:0] rf_addr,
    output logic         rf_reg_write_en,
    output logic         rf_acc_write_en,
    output logic [W-1:0] rf_data_in,
    input  logic [W-1:0] rf_data_out_reg,
    output logic         init_done
);

    localparam int            SW         = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [D-1:0]  LAST_IDX   = D'(NUM_REGS - 1);

    ctrl_state_e   state;
    logic [D-1:0]  init_cnt;
    logic [SW-1:0] starve_cnt;
    dbg_req_t      dbg;
    logic          grant;

    assign dbg = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

    // The ack cycle masks dbg_req so a still-asserted request is not served twice.
    assign grant = (state == ST_RUN) && dbg_req && !dbg_ack &&
                   (core_hold || (starve_cnt == STARVE_MAX));

    // State, counters and all registered outputs.
    // NOTE: every register here is assigned with <= so that all of them sample
    // the same pre-edge values; a blocking = would let later lines see new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            starve_cnt <= '0;
            dbg_ack    <= 1'b0;
            dbg_rdata  <= '0;
            init_done  <= 1'b0;
            core_stall <= 1'b1;
        end else begin
            dbg_ack <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_IDX) begin
                        state      <= ST_RUN;
                        init_done  <= 1'b1;
                        core_stall <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (grant) begin
                        state      <= ST_DBG;
                        core_stall <= 1'b1;
                        starve_cnt <= '0;
                    end else if (!dbg_req) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ST_DBG: begin
                    // Read-before-write: the file still presents the old entry value.
                    state      <= ST_RUN;
                    core_stall <= 1'b0;
                    dbg_ack    <= 1'b1;
                    dbg_rdata  <= rf_data_out_reg;
                end
                default: begin
                    state      <= ST_INIT;
                    init_cnt   <= '0;
                    core_stall <= 1'b1;
                end
            endcase
            if (state != ST_RUN && !dbg_req) begin
                starve_cnt <= '0;
            end
        end
    end

    // Register-file port mux; reset forces every control to zero immediately.
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rf_addr         = '0;
        rf_reg_write_en = 1'b0;
        rf_acc_write_en = 1'b0;
        rf_data_in      = '0;
        if (!rst) begin
            case (state)
                ST_INIT: begin
                    rf_addr         = init_cnt;
                    rf_reg_write_en = 1'b1;
                end
                ST_RUN: begin
                    rf_addr         = core_addr;
                    rf_data_in      = core_data;
                    rf_acc_write_en = core_acc_we;
                    rf_reg_write_en = core_reg_we & ~core_acc_we;
                end
                ST_DBG: begin
                    rf_addr         = dbg.addr;
                    rf_reg_write_en = dbg.we;
                    rf_data_in      = dbg.wdata;
                end
                default: begin
                    rf_addr = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Self-checking bench for reg_file_ctrl: a behavioural register file sits beside
// the controller, and an independent array of expected entry values is updated
// from the access rules to predict every debug read and the final contents.
module tb_reg_file_ctrl;
    import reg_ctrl_pkg::*;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int LIM = 4;
    localparam logic [D-1:0] POKE_ADDR = 4'd7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [D-1:0] core_addr = '0;
    logic         core_reg_we = 1'b0;
    logic         core_acc_we = 1'b0;
    logic [W-1:0] core_data = '0;
    logic         core_hold = 1'b1;
    logic         core_stall;
    logic         dbg_req = 1'b0;
    logic         dbg_we = 1'b0;
    logic [D-1:0] dbg_addr = '0;
    logic [W-1:0] dbg_wdata = '0;
    logic         dbg_ack;
    logic [W-1:0] dbg_rdata;
    logic [D-1:0] rf_addr;
    logic         rf_reg_write_en;
    logic         rf_acc_write_en;
    logic [W-1:0] rf_data_in;
    logic [W-1:0] rf_data_out_reg;
    logic         init_done;

    logic [W-1:0] rf_mem   [NUM_REGS];
    logic [W-1:0] ref_regs [NUM_REGS];
    logic         scribble = 1'b0;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    reg_file_ctrl #(.W(W), .D(D), .STARVE_LIM(LIM)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_addr       (core_addr),
        .core_reg_we     (core_reg_we),
        .core_acc_we     (core_acc_we),
        .core_data       (core_data),
        .core_hold       (core_hold),
        .core_stall      (core_stall),
        .dbg_req         (dbg_req),
        .dbg_we          (dbg_we),
        .dbg_addr        (dbg_addr),
        .dbg_wdata       (dbg_wdata),
        .dbg_ack         (dbg_ack),
        .dbg_rdata       (dbg_rdata),
        .rf_addr         (rf_addr),
        .rf_reg_write_en (rf_reg_write_en),
        .rf_acc_write_en (rf_acc_write_en),
        .rf_data_in      (rf_data_in),
        .rf_data_out_reg (rf_data_out_reg),
        .init_done       (init_done)
    );

    // Behavioural register file; scribble fills it with nonzero junk during reset.
    always @(posedge clk) begin
        if (scribble) begin
            for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= 8'(8'h80 + i);
        end else begin
            if (rf_acc_write_en) rf_mem[ACC_ADDR] <= rf_data_in;
            if (rf_reg_write_en) rf_mem[rf_addr] <= rf_data_in;
        end
    end
    assign rf_data_out_reg = rf_mem[rf_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; scribble = 1'b1;
        dbg_req = 1'b0; core_reg_we = 1'b0; core_acc_we = 1'b0;
        core_addr = 4'hB; core_data = 8'hC3; core_hold = 1'b1;
        @(negedge clk);
        scribble = 1'b0;
        #1;
        total++;
        if ({core_stall, init_done, dbg_ack, dbg_rdata, rf_reg_write_en, rf_acc_write_en, rf_addr, rf_data_in}
            !== {1'b1, 24'h0}) begin
            bad++;
            $display("FAIL reset_values: got stall=%b done=%b ack=%b rdata=%h rwe=%b awe=%b addr=%h din=%h want 1,0,0,00,0,0,0,00",
                     core_stall, init_done, dbg_ack, dbg_rdata, rf_reg_write_en, rf_acc_write_en, rf_addr, rf_data_in);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Checks the clear sequence cycle by cycle for `upto` cycles from reset release.
    task automatic run_init(input int upto);
        for (int i = 0; i < upto; i++) begin
            #1;
            total++;
            if ({rf_reg_write_en, rf_acc_write_en, rf_addr, rf_data_in, core_stall, init_done, dbg_ack}
                !== {1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL init_cycle_%0d: got rwe=%b awe=%b addr=%h din=%h stall=%b done=%b ack=%b want 1,0,%h,00,1,0,0",
                         i, rf_reg_write_en, rf_acc_write_en, rf_addr, rf_data_in, core_stall, init_done, dbg_ack, 4'(i));
            end
            @(negedge clk);
        end
        if (upto == NUM_REGS) begin
            #1;
            total++;
            if ({init_done, core_stall} !== 2'b10) begin
                bad++;
                $display("FAIL init_done: got done=%b stall=%b want done=1 stall=0", init_done, core_stall);
            end
            for (int i = 0; i < NUM_REGS; i++) ref_regs[i] = '0;
        end
    endtask

    task automatic check_mem_matches(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            total++;
            if (rf_mem[i] !== ref_regs[i]) begin
                bad++;
                $display("FAIL %s_r%0d: got %h want %h", tag, i, rf_mem[i], ref_regs[i]);
            end
        end
    endtask

    // One debug access; `keep` leaves dbg_req high through the ack cycle, `extra`
    // adds the cycles such a held request must wait, `poke` drives a core write
    // during the debug cycle that must be dropped.
    task automatic dbg_access(input logic we, input logic [D-1:0] addr, input logic [W-1:0] wdata,
                              input logic hold, input logic poke, input logic keep, input int extra);
        int           lat;
        int           stall_cycles;
        int           exp_lat;
        logic [W-1:0] exp_rd;
        logic         seen;
        exp_lat = (hold ? 2 : LIM + 2) + extra;
        exp_rd  = ref_regs[addr];
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        core_hold = hold; core_reg_we = 1'b0; core_acc_we = 1'b0;
        lat = 0; stall_cycles = 0; seen = 1'b0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            core_reg_we = 1'b0;
            #1;
            if (dbg_ack === 1'b1) begin
                seen = 1'b1;
            end else if (core_stall === 1'b1) begin
                stall_cycles++;
                if (poke) begin
                    core_reg_we = 1'b1; core_addr = POKE_ADDR; core_data = 8'hEE;
                    #1;
                end
                total++;
                if ({rf_addr, rf_reg_write_en, rf_acc_write_en, rf_data_in} !== {addr, we, 1'b0, wdata}) begin
                    bad++;
                    $display("FAIL dbg_port: got addr=%h rwe=%b awe=%b din=%h want %h,%b,0,%h",
                             rf_addr, rf_reg_write_en, rf_acc_write_en, rf_data_in, addr, we, wdata);
                end
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL dbg_timeout: no ack after %0d cycles for addr %h", lat, addr);
        end else begin
            total++;
            if (lat != exp_lat) begin
                bad++;
                $display("FAIL dbg_latency: got %0d edges want %0d", lat, exp_lat);
            end
            total++;
            if (stall_cycles != 1) begin
                bad++;
                $display("FAIL dbg_stall_len: got %0d cycles want 1", stall_cycles);
            end
            if (dbg_rdata !== exp_rd) begin
                bad++;
                $display("FAIL dbg_rdata_r%0d: got %h want %h", addr, dbg_rdata, exp_rd);
            end
        end
        if (we) ref_regs[addr] = wdata;
        if (!keep) begin
            dbg_req = 1'b0; core_hold = 1'b1;
            @(negedge clk);
            #1;
            total++;
            if ({dbg_ack, core_stall} !== 2'b00) begin
                bad++;
                $display("FAIL dbg_after: got ack=%b stall=%b want 0,0", dbg_ack, core_stall);
            end
        end
    endtask

    task automatic core_write(input logic reg_we, input logic acc_we, input logic [D-1:0] addr,
                              input logic [W-1:0] data, input logic hold);
        core_reg_we = reg_we; core_acc_we = acc_we; core_addr = addr; core_data = data; core_hold = hold;
        #1;
        total++;
        if ({rf_acc_write_en, rf_reg_write_en, rf_addr, rf_data_in, core_stall}
            !== {acc_we, reg_we & ~acc_we, addr, data, 1'b0}) begin
            bad++;
            $display("FAIL core_port: got awe=%b rwe=%b addr=%h din=%h stall=%b want %b,%b,%h,%h,0",
                     rf_acc_write_en, rf_reg_write_en, rf_addr, rf_data_in, core_stall,
                     acc_we, reg_we & ~acc_we, addr, data);
        end
        if (acc_we) ref_regs[ACC_ADDR] = data;
        else if (reg_we) ref_regs[addr] = data;
        @(negedge clk);
        core_reg_we = 1'b0; core_acc_we = 1'b0; core_hold = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        run_init(NUM_REGS);
        check_mem_matches("clear");
        dbg_access(1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        dbg_access(1'b0, 4'd15, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_acc_priority();
        core_write(1'b1, 1'b1, 4'd5, 8'hA7, 1'b0);
        dbg_access(1'b0, 4'd15, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        dbg_access(1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_debug_write();
        dbg_access(1'b1, 4'd9, 8'h3C, 1'b1, 1'b0, 1'b0, 0);
        dbg_access(1'b0, 4'd9, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_starvation();
        dbg_access(1'b1, 4'd12, 8'h5A, 1'b0, 1'b1, 1'b0, 0);
        dbg_access(1'b0, POKE_ADDR, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        dbg_access(1'b0, 4'd12, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_read_before_write();
        core_write(1'b1, 1'b0, 4'd2, 8'h55, 1'b0);
        dbg_access(1'b1, 4'd2, 8'h11, 1'b1, 1'b0, 1'b0, 0);
        dbg_access(1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        dbg_access(1'b1, 4'd4, 8'h99, 1'b1, 1'b0, 1'b1, 0);
        dbg_access(1'b0, 4'd4, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                core_write(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
            end else begin
                dbg_access(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0, 0);
            end
        end
        check_mem_matches("random");
    endtask

    task automatic test_reset_abort();
        apply_reset();
        run_init(7);
        #1;
        total++;
        if (rf_addr !== 4'd7) begin
            bad++;
            $display("FAIL abort_init_pos: got addr=%h want 7", rf_addr);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({rf_reg_write_en, rf_acc_write_en, rf_addr, rf_data_in, core_stall} !== {14'h0, 1'b1}) begin
            bad++;
            $display("FAIL abort_init_force: got rwe=%b awe=%b addr=%h din=%h stall=%b want 0,0,0,00,1",
                     rf_reg_write_en, rf_acc_write_en, rf_addr, rf_data_in, core_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        run_init(NUM_REGS);
        check_mem_matches("abort_init");

        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd6; dbg_wdata = 8'h77; core_hold = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (core_stall !== 1'b1) begin
            bad++;
            $display("FAIL abort_dbg_entry: got stall=%b want 1", core_stall);
        end
        rst = 1'b1;
        dbg_req = 1'b0;
        #1;
        total++;
        if ({dbg_ack, rf_reg_write_en, rf_addr, rf_data_in} !== 14'h0) begin
            bad++;
            $display("FAIL abort_dbg_force: got ack=%b rwe=%b addr=%h din=%h want 0,0,0,00",
                     dbg_ack, rf_reg_write_en, rf_addr, rf_data_in);
        end
        @(negedge clk);
        rst = 1'b0;
        run_init(NUM_REGS);
        check_mem_matches("abort_dbg");
    endtask

    initial begin
        test_reset();
        test_acc_priority();
        test_debug_write();
        test_starvation();
        test_read_before_write();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
